dot_acc_sched: RTL and testbench



---
 rtl/dot_acc_sched.sv | 208 ++++++++++++++++++++
 tb/tb_dot_acc_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_acc_sched.sv
// Sequences multi-chunk dot-product rows through a shared, non-stallable adder tree,
// accumulates per-chunk tree sums into row sums and buffers finished rows in a small FIFO.
module dot_acc_sched #(
    parameter int ADDEND_WIDTH  = 8,
    parameter int DIM           = 128,
    parameter int SUM_WIDTH     = 15,
    parameter int NUM_CHUNK_MAX = 16,
    parameter int CNT_WIDTH     = 5,
    parameter int ACC_WIDTH     = 19,
    parameter int TREE_LATENCY  = 7,
    parameter int OUT_DEPTH     = 2
) (
    input  logic                        clk_p,
    input  logic                        rst_n,
    input  logic [CNT_WIDTH-1:0]        cfg_num_chunk,
    input  logic [ADDEND_WIDTH*DIM-1:0] in_data,
    input  logic                        in_valid_n,
    output logic                        in_ready,
    output logic [ADDEND_WIDTH*DIM-1:0] tree_addend,
    output logic                        tree_addend_valid_n,
    input  logic [SUM_WIDTH-1:0]        tree_sum,
    input  logic                        tree_sum_valid_n,
    output logic [ACC_WIDTH-1:0]        out_sum,
    output logic                        out_valid_n,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        err_sync
);

    localparam int DATA_W = ADDEND_WIDTH * DIM;
    localparam int TAGS   = TREE_LATENCY + 1;
    localparam int FCW    = $clog2(OUT_DEPTH + 1);
    localparam int PW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef enum logic {IDLE, ROW} state_t;

    state_t state_q, state_d;

    logic [CNT_WIDTH-1:0] n_lat_q, n_lat_d;
    logic [CNT_WIDTH-1:0] chunk_idx_q, chunk_idx_d;
    logic [CNT_WIDTH-1:0] chunk_idx_inc;
    logic [FCW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [FCW-1:0]       rows_pend_q, rows_pend_d;
    logic [FCW:0]         credit_used;
    logic [TAGS-1:0]      tag_v_q, tag_v_d;
    logic [TAGS-1:0]      tag_first_q, tag_first_d;
    logic [TAGS-1:0]      tag_last_q, tag_last_d;
    logic [DATA_W-1:0]    tree_addend_q, tree_addend_d;
    logic                 tree_valid_n_q, tree_valid_n_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] sum_ext;
    logic                 err_q, err_d;
    logic [ACC_WIDTH-1:0] fifo_mem_q [OUT_DEPTH];
    logic [ACC_WIDTH-1:0] fifo_mem_d [OUT_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

    logic cfg_ok, credit_ok, accept, row_open;
    logic tag_first, tag_last;
    logic tail_v, tail_first, tail_last;
    logic push, pop;

    assign chunk_idx_inc = chunk_idx_q + CNT_WIDTH'(1);
    assign cfg_ok        = (cfg_num_chunk != '0) && (cfg_num_chunk <= CNT_WIDTH'(NUM_CHUNK_MAX));
    assign credit_used   = {1'b0, fifo_cnt_q} + {1'b0, rows_pend_q};
    assign credit_ok     = credit_used < (FCW+1)'(OUT_DEPTH);
    assign accept        = !in_valid_n && in_ready;
    assign row_open      = accept && (state_q == IDLE);

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (cfg_num_chunk != CNT_WIDTH'(1))) state_d = ROW;
            ROW:  if (accept && (chunk_idx_inc == n_lat_q))       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A row only opens with a legal length and a free output slot reserved for it.
    always_comb begin
        in_ready  = 1'b0;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready  = cfg_ok && credit_ok;
                tag_first = 1'b1;
                tag_last  = (cfg_num_chunk == CNT_WIDTH'(1));
            end
            ROW: begin
                in_ready  = 1'b1;
                tag_last  = (chunk_idx_inc == n_lat_q);
            end
            default: ;
        endcase
    end

    assign tail_v     = tag_v_q[TAGS-1];
    assign tail_first = tag_first_q[TAGS-1];
    assign tail_last  = tag_last_q[TAGS-1];
    assign sum_ext    = {{(ACC_WIDTH-SUM_WIDTH){tree_sum[SUM_WIDTH-1]}}, tree_sum};
    assign acc_sum    = tail_first ? sum_ext : acc_q + sum_ext;
    assign push       = tail_v && tail_last;
    assign pop        = (fifo_cnt_q != '0) && out_ready;

    // The tag pipe follows the tree's fixed latency, so the tail tag names the current tree_sum.
    always_comb begin
        n_lat_d        = n_lat_q;
        chunk_idx_d    = chunk_idx_q;
        tree_addend_d  = tree_addend_q;
        tree_valid_n_d = !accept;
        tag_v_d        = {tag_v_q[TAGS-2:0], accept};
        tag_first_d    = {tag_first_q[TAGS-2:0], accept && tag_first};
        tag_last_d     = {tag_last_q[TAGS-2:0], accept && tag_last};
        acc_d          = acc_q;
        err_d          = err_q || (tail_v == tree_sum_valid_n);
        if (accept) begin
            tree_addend_d = in_data;
            if (state_q == IDLE) begin
                n_lat_d     = cfg_num_chunk;
                chunk_idx_d = CNT_WIDTH'(1);
            end else begin
                chunk_idx_d = chunk_idx_inc;
            end
        end
        if (tail_v) begin
            acc_d = acc_sum;
        end
    end

    always_comb begin
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        rows_pend_d = rows_pend_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = acc_sum;
            wr_ptr_d = (wr_ptr_q == PW'(OUT_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(OUT_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        case ({row_open, push})
            2'b10:   rows_pend_d = rows_pend_q + FCW'(1);
            2'b01:   rows_pend_d = rows_pend_q - FCW'(1);
            default: rows_pend_d = rows_pend_q;
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            n_lat_q        <= '0;
            chunk_idx_q    <= '0;
            tree_addend_q  <= '0;
            tree_valid_n_q <= 1'b1;
            tag_v_q        <= '0;
            tag_first_q    <= '0;
            tag_last_q     <= '0;
            acc_q          <= '0;
            err_q          <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            rows_pend_q    <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            n_lat_q        <= n_lat_d;
            chunk_idx_q    <= chunk_idx_d;
            tree_addend_q  <= tree_addend_d;
            tree_valid_n_q <= tree_valid_n_d;
            tag_v_q        <= tag_v_d;
            tag_first_q    <= tag_first_d;
            tag_last_q     <= tag_last_d;
            acc_q          <= acc_d;
            err_q          <= err_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fifo_cnt_q     <= fifo_cnt_d;
            rows_pend_q    <= rows_pend_d;
            fifo_mem_q     <= fifo_mem_d;
        end
    end

    assign tree_addend         = tree_addend_q;
    assign tree_addend_valid_n = tree_valid_n_q;
    assign out_sum             = fifo_mem_q[rd_ptr_q];
    assign out_valid_n         = (fifo_cnt_q == '0);
    assign busy                = (state_q == ROW) || (tag_v_q != '0) || (fifo_cnt_q != '0);
    assign err_sync            = err_q;

endmodule

// File: tb/tb_dot_acc_sched.sv
// Bench for dot_acc_sched: models the 7-cycle adder tree and predicts row sums
// directly from the chunk data it sends, checking every popped output in order.
module tb_dot_acc_sched;

    localparam int DW = 1024;

    logic          clk_p = 1'b0;
    logic          rst_n;
    logic [4:0]    cfg_num_chunk;
    logic [DW-1:0] in_data;
    logic          in_valid_n;
    logic          in_ready;
    logic [DW-1:0] tree_addend;
    logic          tree_addend_valid_n;
    logic [14:0]   tree_sum;
    logic          tree_sum_valid_n;
    logic [18:0]   out_sum;
    logic          out_valid_n;
    logic          out_ready;
    logic          busy;
    logic          err_sync;

    int vectors = 0;
    int miscompares = 0;
    int accept_cnt = 0;
    int tree_valid_cnt = 0;
    int pop_cnt = 0;
    logic rand_ready = 1'b0;
    logic inject = 1'b0;
    logic [18:0] exp_q[$];

    logic [6:0]  tp_v;
    logic [14:0] tp_sum [7];

    dot_acc_sched dut (
        .clk_p(clk_p), .rst_n(rst_n), .cfg_num_chunk(cfg_num_chunk),
        .in_data(in_data), .in_valid_n(in_valid_n), .in_ready(in_ready),
        .tree_addend(tree_addend), .tree_addend_valid_n(tree_addend_valid_n),
        .tree_sum(tree_sum), .tree_sum_valid_n(tree_sum_valid_n),
        .out_sum(out_sum), .out_valid_n(out_valid_n), .out_ready(out_ready),
        .busy(busy), .err_sync(err_sync)
    );

    always #5 clk_p = ~clk_p;

    function automatic int chunkSum(input logic [DW-1:0] d);
        int s = 0;
        for (int i = 0; i < 128; i++) s += int'($signed(d[i*8 +: 8]));
        return s;
    endfunction

    function automatic logic [DW-1:0] fillConst(input int v);
        logic [DW-1:0] d;
        for (int i = 0; i < 128; i++) d[i*8 +: 8] = v[7:0];
        return d;
    endfunction

    // Adder-tree model: fully pipelined, 7 cycles from addend valid to sum valid.
    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            tp_v <= '0;
            for (int i = 0; i < 7; i++) tp_sum[i] <= '0;
        end else begin
            tp_v      <= {tp_v[5:0], !tree_addend_valid_n};
            tp_sum[0] <= 15'(chunkSum(tree_addend));
            for (int i = 1; i < 7; i++) tp_sum[i] <= tp_sum[i-1];
        end
    end

    assign tree_sum         = tp_sum[6];
    assign tree_sum_valid_n = !(tp_v[6] || inject);

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, after the negedge stimulus has settled.
    always @(negedge clk_p) begin
        #2;
        if (rst_n) begin
            if (!in_valid_n && in_ready) accept_cnt++;
            if (!tree_addend_valid_n) tree_valid_cnt++;
            if (!out_valid_n && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) checkOutput("pop_unexpected", 64'(out_valid_n), 64'd1);
                else checkOutput("pop_sum", 64'(out_sum), 64'(exp_q.pop_front()));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic applyStimulus(input logic [DW-1:0] d, input int cfg);
        logic r;
        bit ok = 0;
        cfg_num_chunk = 5'(cfg);
        in_data = d;
        in_valid_n = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            r = in_ready;
            @(negedge clk_p);
            if (r) ok = 1;
        end
        if (!ok) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    // kind 0: every element = val; kind 1: chunk k elements = k+1; kind 2: random data, noisy cfg mid-row.
    task automatic sendRow(input int n, input int kind, input int val);
        logic [DW-1:0] d;
        int total = 0;
        int cfg;
        for (int k = 0; k < n; k++) begin
            if (kind == 0) d = fillConst(val);
            else if (kind == 1) d = fillConst(k + 1);
            else for (int i = 0; i < 128; i++) d[i*8 +: 8] = 8'($urandom);
            cfg = (k == 0 || kind != 2) ? n : int'($urandom_range(0, 31));
            total += chunkSum(d);
            applyStimulus(d, cfg);
        end
        in_valid_n = 1'b1;
        exp_q.push_back(19'(total));
    endtask

    task automatic waitIdle();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_p);
            #1;
            if (!busy && exp_q.size() == 0) break;
        end
        checkOutput("drain_busy", 64'(busy), 64'd0);
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk_p);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_tav_n", 64'(tree_addend_valid_n), 64'd1);
        checkOutput("rst_addend_nz", 64'(|tree_addend), 64'd0);
        checkOutput("rst_out_valid_n", 64'(out_valid_n), 64'd1);
        checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err_sync), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_p);
        rst_n = 1'b1;
        @(negedge clk_p);
    endtask

    initial begin
        int lat;
        int bad;
        bit found;
        in_valid_n = 1'b1;
        in_data = '0;
        cfg_num_chunk = 5'd1;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk_p);
        doReset();

        #1;
        checkOutput("idle_ready_cfg1", 64'(in_ready), 64'd1);
        cfg_num_chunk = 5'd0;
        #1;
        checkOutput("idle_ready_cfg0", 64'(in_ready), 64'd0);
        cfg_num_chunk = 5'd17;
        #1;
        checkOutput("idle_ready_cfg17", 64'(in_ready), 64'd0);
        @(negedge clk_p);

        // N=1 all ones: latency from accept edge to out_valid_n low.
        sendRow(1, 0, 1);
        lat = 0;
        found = 0;
        for (int k = 1; k <= 30 && !found; k++) begin
            #1;
            if (k == 1) checkOutput("tav_low_after_accept", 64'(tree_addend_valid_n), 64'd0);
            if (k == 2) checkOutput("tav_high_after_one", 64'(tree_addend_valid_n), 64'd1);
            if (!out_valid_n) begin
                found = 1;
                lat = k;
            end else @(negedge clk_p);
        end
        checkOutput("latency_n1", 64'(lat), 64'd9);
        @(negedge clk_p);
        waitIdle();

        // N=4 back-to-back, chunk k = k+1.
        tree_valid_cnt = 0;
        pop_cnt = 0;
        sendRow(4, 1, 0);
        #1;
        checkOutput("busy_in_flight", 64'(busy), 64'd1);
        @(negedge clk_p);
        waitIdle();
        checkOutput("n4_tree_valids", 64'(tree_valid_cnt), 64'd4);
        checkOutput("n4_pops", 64'(pop_cnt), 64'd1);

        // N=16 all -128: most negative row sum.
        sendRow(16, 0, -128);
        waitIdle();
        checkOutput("n16_err", 64'(err_sync), 64'd0);

        // Backpressure: two credits, third row waits for a pop.
        out_ready = 1'b0;
        accept_cnt = 0;
        sendRow(1, 0, 1);
        sendRow(1, 0, 2);
        in_data = fillConst(3);
        cfg_num_chunk = 5'd1;
        in_valid_n = 1'b0;
        exp_q.push_back(19'd384);
        repeat (15) @(negedge clk_p);
        #1;
        checkOutput("bp_accepts", 64'(accept_cnt), 64'd2);
        checkOutput("bp_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk_p);
        out_ready = 1'b1;
        #1;
        checkOutput("credit_hold", 64'(in_ready), 64'd0);
        @(negedge clk_p);
        #1;
        checkOutput("credit_free", 64'(in_ready), 64'd1);
        @(negedge clk_p);
        in_valid_n = 1'b1;
        checkOutput("bp_accepts_after", 64'(accept_cnt), 64'd3);
        waitIdle();

        // Illegal config: nothing accepted, nothing issued.
        cfg_num_chunk = 5'd0;
        in_valid_n = 1'b0;
        in_data = fillConst(5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready || !tree_addend_valid_n) bad++;
            @(negedge clk_p);
        end
        checkOutput("illegal_cfg_activity", 64'(bad), 64'd0);
        sendRow(3, 2, 0);
        waitIdle();

        // Reset mid-row drops everything.
        applyStimulus(fillConst(1), 4);
        applyStimulus(fillConst(1), 4);
        in_valid_n = 1'b1;
        doReset();
        sendRow(2, 0, 1);
        waitIdle();

        // Randomized rows with random output backpressure.
        for (int r = 0; r < 12; r++) begin
            rand_ready = 1'b1;
            sendRow(int'($urandom_range(1, 16)), 2, 0);
        end
        waitIdle();
        checkOutput("rand_err", 64'(err_sync), 64'd0);

        // Tree valid with no tag in flight sets a sticky error.
        inject = 1'b1;
        @(negedge clk_p);
        inject = 1'b0;
        #1;
        checkOutput("err_set", 64'(err_sync), 64'd1);
        repeat (5) @(negedge clk_p);
        #1;
        checkOutput("err_sticky", 64'(err_sync), 64'd1);
        @(negedge clk_p);
        doReset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
